// File: rtl/cnn_mac_pkg.sv
// Shared types for the CNN MAC control blocks: sequencer state encoding and
// the flag word that travels down the multiplier-latency delay line.
package cnn_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic valid;  // a tap was issued in this slot
    logic first;  // tap 0 of its window
    logic last;   // tap TAPS-1 of its window
  } dly_flags_t;

  localparam int FLAG_W      = $bits(dly_flags_t);
  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the layer controller (master)
// and the MAC sequencer (slave).
interface mac_seq_ctrl_if #(
  parameter int TAP_W = 4,
  parameter int WIN_W = 8
);
  import cnn_mac_pkg::*;

  logic                   start;
  logic [WIN_W-1:0]       num_win;
  logic                   stall;
  logic                   busy;
  logic                   done;
  logic [TAP_W-1:0]       tap_idx;
  logic [WIN_W-1:0]       win_idx;
  logic                   issue;
  logic                   acc_load;
  logic                   acc_en;
  logic                   out_valid;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output start, num_win, stall,
    input  busy, done, tap_idx, win_idx, issue, acc_load, acc_en, out_valid, stall_cnt
  );

  modport slave (
    input  start, num_win, stall,
    output busy, done, tap_idx, win_idx, issue, acc_load, acc_en, out_valid, stall_cnt
  );

endinterface

// File: rtl/mac_ctrl_dly.sv
// DEPTH-stage flag shift register; shifts every cycle so empty slots travel
// as bubbles. Reusable by any pipelined CNN control block.
module mac_ctrl_dly #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC control sequencer: NUM_WIN windows x TAPS taps, accumulator controls
// aligned to PIPE_LAT. Define MAC_SEQ_PERF_EN to build the stall counter.
module mac_seq_ctrl
  import cnn_mac_pkg::*;
#(
  parameter int TAPS     = 9,
  parameter int PIPE_LAT = 2,
  parameter int WIN_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.slave  bus
);

  localparam int TAP_W = $clog2(TAPS);
  localparam int DRN_W = $clog2(PIPE_LAT + 2);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT);

  seq_state_t       state;
  logic [TAP_W-1:0] tap_reg;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] nwin_reg;
  logic [DRN_W-1:0] drn_reg;
  logic             out_valid_reg;
  logic             issue;
  dly_flags_t       flags_in;
  dly_flags_t       flags_out;

  assign issue = (state == ST_RUN) && !bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tap_reg  <= '0;
      win_reg  <= '0;
      nwin_reg <= '0;
      drn_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            nwin_reg <= bus.num_win;
            tap_reg  <= '0;
            win_reg  <= '0;
            state    <= (bus.num_win == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (tap_reg == TAP_LAST) begin
              tap_reg <= '0;
              // Indices return to 0 after the final tap so they never exceed num_win-1.
              if (win_reg == nwin_reg - WIN_W'(1)) begin
                win_reg <= '0;
                drn_reg <= '0;
                state   <= ST_DRAIN;
              end else begin
                win_reg <= win_reg + WIN_W'(1);
              end
            end else begin
              tap_reg <= tap_reg + TAP_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drn_reg == DRN_LAST) begin
            state <= ST_DONE;
          end else begin
            drn_reg <= drn_reg + DRN_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    flags_in       = '0;
    flags_in.valid = issue;
    flags_in.first = issue && (tap_reg == '0);
    flags_in.last  = issue && (tap_reg == TAP_LAST);
  end

  mac_ctrl_dly #(
    .W     (FLAG_W),
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d   (flags_in),
    .q   (flags_out)
  );

  // The final product lands on this edge; the sum is readable the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= flags_out.valid && flags_out.last;
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((state == ST_IDLE) && bus.start) begin
      stall_cnt_reg <= '0;
    end else if ((state == ST_RUN) && bus.stall && (stall_cnt_reg != STALL_CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.tap_idx   = tap_reg;
  assign bus.win_idx   = win_reg;
  assign bus.issue     = issue;
  assign bus.acc_en    = flags_out.valid;
  assign bus.acc_load  = flags_out.valid && flags_out.first;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: random jobs/stalls, a behavioural MAC
// datapath model in the monitor, and per-job done/busy/stall checks.
module tb_mac_seq_ctrl;

  localparam int TAPS     = 9;
  localparam int PIPE_LAT = 2;
  localparam int WIN_W    = 8;
  localparam int TAP_W    = $clog2(TAPS);
  localparam int MAXW     = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.TAP_W(TAP_W), .WIN_W(WIN_W)) bus ();

  mac_seq_ctrl #(.TAPS(TAPS), .PIPE_LAT(PIPE_LAT), .WIN_W(WIN_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int w; int t; } iss_t;
  typedef struct { int cyc; int busy; int stalls; } done_t;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  iss_t        iss_q[$];
  int unsigned sum_q[$];
  done_t       done_q[$];
  int unsigned prod_mem [MAXW][TAPS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: models the multiplier pipeline and accumulator driven by the DUT controls.
  int unsigned pipe [PIPE_LAT];
  int unsigned acc;
  int unsigned p_out;
  int unsigned p_new;
  int          bcnt;
  iss_t        e;
  done_t       d;

  always @(negedge clk) begin
    if (rst) begin
      acc  = 0;
      bcnt = 0;
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] = 0;
    end else begin
      p_out = pipe[PIPE_LAT-1];
      if (bus.out_valid) begin
        check("out_valid_expected", 64'(sum_q.size() > 0), 64'(1));
        if (sum_q.size() > 0) check("window_sum", 64'(acc), 64'(sum_q.pop_front()));
      end
      if (bus.acc_load) check("acc_load_with_acc_en", 64'(bus.acc_en), 64'(1));
      if (bus.acc_en) acc = bus.acc_load ? p_out : acc + p_out;

      p_new = $urandom_range(1, 255);
      if (bus.issue) begin
        check("issue_expected", 64'(iss_q.size() > 0), 64'(1));
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          check("tap_idx", 64'(bus.tap_idx), 64'(e.t));
          check("win_idx", 64'(bus.win_idx), 64'(e.w));
        end
        if (int'(bus.tap_idx) < TAPS && int'(bus.win_idx) < MAXW)
          p_new = prod_mem[bus.win_idx][bus.tap_idx];
      end
      for (int i = PIPE_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = p_new;

      if (bus.busy) bcnt++; else bcnt = 0;
      if (bus.done) begin
        check("done_expected", 64'(done_q.size() > 0), 64'(1));
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("busy_cycles", 64'(bcnt), 64'(d.busy));
`ifdef MAC_SEQ_PERF_EN
          check("stall_cnt", 64'(bus.stall_cnt), 64'(d.stalls));
`else
          check("stall_cnt", 64'(bus.stall_cnt), 64'(0));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: every window issues taps 0..TAPS-1 in order; its sum is the plain product total.
  task automatic push_expect(input int n);
    int unsigned sum;
    for (int w = 0; w < n; w++) begin
      sum = 0;
      for (int t = 0; t < TAPS; t++) begin
        prod_mem[w][t] = $urandom_range(0, 255);
        sum += prod_mem[w][t];
        iss_q.push_back('{w, t});
      end
      sum_q.push_back(sum);
    end
  endtask

  task automatic run_job(input int n, input int pct, input bit spurious);
    int s, rem, stalls, done_c;
    bit st;
    push_expect(n);
    bus.start   = 1'b1;
    bus.num_win = WIN_W'(n);
    bus.stall   = 1'b0;
    s = cyc;
    tick();
    bus.start   = 1'b0;
    bus.num_win = WIN_W'($urandom);
    rem    = n * TAPS;
    stalls = 0;
    // Each RUN cycle either issues one tap or is stalled.
    while (rem > 0) begin
      st = ($urandom_range(0, 99) < pct);
      if (st) stalls++; else rem--;
      bus.stall   = st;
      bus.start   = spurious && ($urandom_range(0, 9) == 0);
      bus.num_win = WIN_W'($urandom);
      tick();
    end
    bus.start = 1'b0;
    done_c = (n == 0) ? s + 1 : s + n * TAPS + stalls + PIPE_LAT + 2;
    done_q.push_back('{done_c, done_c - s, stalls});
    while (cyc <= done_c) begin
      bus.stall = 1'($urandom_range(0, 1));
      tick();
    end
    bus.stall = 1'b0;
    $display("job num_win=%0d stall_pct=%0d stalls=%0d start=%0d done=%0d", n, pct, stalls, s, done_c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.num_win = WIN_W'(3);
    bus.stall   = 1'b0;
    tick();
    tick();
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_done",      64'(bus.done),      64'(0));
    check("rst_issue",     64'(bus.issue),     64'(0));
    check("rst_acc_en",    64'(bus.acc_en),    64'(0));
    check("rst_acc_load",  64'(bus.acc_load),  64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_tap_idx",   64'(bus.tap_idx),   64'(0));
    check("rst_win_idx",   64'(bus.win_idx),   64'(0));
    check("rst_stall_cnt", 64'(bus.stall_cnt), 64'(0));
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    check("idle_busy",  64'(bus.busy),  64'(0));
    check("idle_issue", 64'(bus.issue), 64'(0));

    run_job(1, 0, 1'b0);
    run_job(3, 0, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(2, 30, 1'b1);
    run_job(1, 40, 1'b1);
    repeat (20) run_job($urandom_range(0, 5), $urandom_range(0, 50), 1'b1);

    // Abort a job with reset in its sixth cycle: everything clears, no done pulse.
    push_expect(4);
    bus.start   = 1'b1;
    bus.num_win = WIN_W'(4);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("abort_busy",      64'(bus.busy),      64'(0));
    check("abort_issue",     64'(bus.issue),     64'(0));
    check("abort_acc_en",    64'(bus.acc_en),    64'(0));
    check("abort_tap_idx",   64'(bus.tap_idx),   64'(0));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    tick();
    rst = 1'b0;
    iss_q.delete();
    sum_q.delete();
    repeat (4) tick();
    check("post_abort_busy", 64'(bus.busy), 64'(0));
    $display("job aborted by reset at cycle %0d", cyc);

    run_job(2, 20, 1'b1);
    repeat (3) tick();
    check("issue_queue_drained", 64'(iss_q.size()),  64'(0));
    check("sum_queue_drained",   64'(sum_q.size()),  64'(0));
    check("done_queue_drained",  64'(done_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
